ibus_cksyn_ctrl: RTL

- Ratio controller for the instruction-bus clock-synchronisation path.
- Divides clk_ungated by a programmable ratio of 1 to 4 and produces:
  - ck_en, the bus clock-enable pulse;
  - toggle, which feeds the downstream sync edge/phase detector.
- Serialises ratio-change requests so a change lands only on a bus-cycle boundary with no transfer in flight.
- Enforces a settle window after each change so the downstream phase detector re-learns the ratio cleanly.

---
 rtl/ibus_cksyn_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ibus_cksyn_ctrl.sv
// ibus_cksyn_ctrl: ratio controller for the instruction-bus clock-sync path.
// Divides clk_ungated by 1..4 to produce the bus clock enable (ck_en) and a
// toggle for the downstream phase detector. Ratio changes are deferred to a
// bus-cycle boundary with no transfer in flight, then followed by a frozen
// settle window so the phase detector can re-learn the new ratio.
//
// Ports:
//   clk_ungated   - free-running core clock, all state on its rising edge
//   rst_a         - asynchronous active-low reset
//   ratio_req     - requested ratio (00=1:1, 01=1:2, 10=1:3, 11=1:4)
//   ratio_req_vld - request valid, held with ratio_req stable until ack
//   ratio_req_ack - one-cycle pulse when a request completes
//   bus_busy      - bus transfer in flight, blocks a ratio switch
//   ck_en         - bus clock enable, one clk_ungated cycle wide
//   toggle        - inverts on every ck_en cycle
//   cur_ratio     - ratio currently in effect
//   switching     - high while a change is draining or settling
//   stop_req/stop_ack - clock stop handshake (IBUS_CKSYN_CTRL_STOP_EN only)
//
// Build option: define IBUS_CKSYN_CTRL_STOP_EN to add the STOP state and the
// stop_req/stop_ack ports.

module ibus_cksyn_ctrl #(
  parameter logic [1:0]  RESET_RATIO   = 2'b00,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk_ungated,
  input  logic       rst_a,
  input  logic [1:0] ratio_req,
  input  logic       ratio_req_vld,
  output logic       ratio_req_ack,
  input  logic       bus_busy,
`ifdef IBUS_CKSYN_CTRL_STOP_EN
  input  logic       stop_req,
  output logic       stop_ack,
`endif
  output logic       ck_en,
  output logic       toggle,
  output logic [1:0] cur_ratio,
  output logic       switching
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

`ifdef IBUS_CKSYN_CTRL_STOP_EN
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE} state_t;
`endif

  state_t     state_r;
  logic [1:0] div_cnt_r;
  logic [1:0] cur_ratio_r;
  logic [1:0] new_ratio_r;
  logic [3:0] settle_cnt_r;
  logic       toggle_r;
  logic       ack_r;
  logic       ack_pend_r;   // settle window was entered from a ratio switch
`ifdef IBUS_CKSYN_CTRL_STOP_EN
  logic       stop_ack_r;
`endif

  // Divider only runs (and enables the bus clock) in RUN and DRAIN.
  assign ck_en = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
                 (div_cnt_r == cur_ratio_r);

  assign toggle        = toggle_r;
  assign ratio_req_ack = ack_r;
  assign cur_ratio     = cur_ratio_r;
  assign switching     = (state_r == ST_DRAIN) || (state_r == ST_SETTLE);
`ifdef IBUS_CKSYN_CTRL_STOP_EN
  assign stop_ack      = stop_ack_r;
`endif

  // Control FSM, divider and handshake registers.
  always_ff @(posedge clk_ungated or negedge rst_a) begin
    if (!rst_a) begin
      state_r      <= ST_SETTLE;
      div_cnt_r    <= 2'd0;
      cur_ratio_r  <= RESET_RATIO;
      new_ratio_r  <= RESET_RATIO;
      settle_cnt_r <= SETTLE_LOAD;
      toggle_r     <= 1'b0;
      ack_r        <= 1'b0;
      ack_pend_r   <= 1'b0;
`ifdef IBUS_CKSYN_CTRL_STOP_EN
      stop_ack_r   <= 1'b0;
`endif
    end else begin
      ack_r <= 1'b0;

      // Divider: counter never passes cur_ratio_r, so no wrap handling.
      if (ck_en) begin
        div_cnt_r <= 2'd0;
        toggle_r  <= ~toggle_r;
      end else if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
        div_cnt_r <= div_cnt_r + 2'd1;
      end

      case (state_r)
        ST_RUN: begin
`ifdef IBUS_CKSYN_CTRL_STOP_EN
          // A pending stop masks ratio requests until it is taken.
          if (stop_req) begin
            if (ck_en && !bus_busy) begin
              state_r    <= ST_STOP;
              stop_ack_r <= 1'b1;
            end
          end else
`endif
          // ack_r stops a still-high request being re-accepted in its ack cycle.
          if (ratio_req_vld && !ack_r) begin
            if (ratio_req == cur_ratio_r) begin
              ack_r <= 1'b1;
            end else begin
              new_ratio_r <= ratio_req;
              state_r     <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // Last edge at the old ratio is issued, then the new ratio takes over.
          if (ck_en && !bus_busy) begin
            cur_ratio_r  <= new_ratio_r;
            settle_cnt_r <= SETTLE_LOAD;
            ack_pend_r   <= 1'b1;
            state_r      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_r == 4'd0) begin
            ack_r      <= ack_pend_r;
            ack_pend_r <= 1'b0;
            state_r    <= ST_RUN;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end

`ifdef IBUS_CKSYN_CTRL_STOP_EN
        ST_STOP: begin
          if (!stop_req) begin
            settle_cnt_r <= SETTLE_LOAD;
            ack_pend_r   <= 1'b0;
            stop_ack_r   <= 1'b0;
            state_r      <= ST_SETTLE;
          end
        end
`endif

        default: begin
          state_r <= ST_SETTLE;
        end
      endcase
    end
  end

endmodule
